// File: rtl/uart_program_loader.sv
// Boot-time program loader: sends a sync byte over UART, receives a big-endian
// word count and then that many big-endian 32-bit words into instruction memory.
module uart_program_loader #(
  parameter int          ADDR_W    = 14,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_REQ, S_RECV_LEN, S_CHECK_LEN,
    S_RECV_WORD, S_WRITE, S_DONE, S_ERR
  } state_e;

  // Largest accepted word count; 33 bits so ADDR_W up to 32 stays exact.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [31:0]         shift_q, shift_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    tx_start    = 1'b0;
    imem_we     = 1'b0;

    // Bytes are collected MSB first in every receiving state, WRITE included,
    // so a strobe landing on the write cycle becomes byte 0 of the next word.
    if (rx_valid && (state_q == S_RECV_LEN || state_q == S_RECV_WORD ||
                     state_q == S_WRITE)) begin
      shift_d    = {shift_q[23:0], rx_data};
      byte_idx_d = byte_idx_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SEND_REQ;
      end
      S_SEND_REQ: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_RECV_LEN;
        end
      end
      S_RECV_LEN: begin
        if (rx_valid && byte_idx_q == 2'd3) state_d = S_CHECK_LEN;
      end
      S_CHECK_LEN: begin
        if (shift_q == 32'd0) begin
          state_d = S_DONE;
        end else if ({1'b0, shift_q} > CAPACITY) begin
          state_d = S_ERR;
        end else begin
          state_d     = S_RECV_WORD;
          remaining_d = shift_q;
          addr_d      = '0;
          byte_idx_d  = 2'd0;
        end
      end
      S_RECV_WORD: begin
        if (rx_valid && byte_idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        imem_we     = 1'b1;
        remaining_d = remaining_q - 32'd1;
        if (remaining_q == 32'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RECV_WORD;
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data    = SYNC_BYTE;
  assign imem_addr  = addr_q;
  assign imem_wdata = shift_q;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader built with ADDR_W=4 so the
// full-capacity and over-capacity word counts stay short.
module tb_uart_program_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    state_dbg;

  int tests = 0;
  int fails = 0;
  int tx_count = 0;
  int tx_bad = 0;

  logic [AW-1:0] act_addr_q[$];
  logic [31:0]   act_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_q[$];

  uart_program_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_busy(tx_busy), .tx_data(tx_data),
    .tx_start(tx_start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // clock / monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      act_addr_q.push_back(imem_addr);
      act_data_q.push_back(imem_wdata);
    end
    if (tx_start === 1'b1) begin
      tx_count++;
      if (tx_busy) tx_bad++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      if (gap) step();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    tx_busy = 1'b0;
    step();
    step();
    rstn = 1'b1;
    act_addr_q.delete();
    act_data_q.delete();
    exp_addr_q.delete();
    exp_q.delete();
    tx_count = 0;
    tx_bad = 0;
  endtask

  // After this the DUT sits in RECV_LEN (transmitter idle).
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  // scoreboard
  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, act_data_q.size(), exp_q.size());
    while (act_data_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_wr_addr"}, 32'(act_addr_q.pop_front()), 32'(exp_addr_q.pop_front()));
      check({tag, "_wr_data"}, act_data_q.pop_front(), exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 32'hAA);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0;

    // Reset held 3 cycles with start high.
    step(); step(); step();
    check_reset_outputs("rst");
    check("rst_tx_count", tx_count, 0);
    rstn = 1'b1;
    start = 1'b0;

    // Normal load, bytes separated by idle cycles.
    do_reset();
    do_start();
    check("norm_tx_count", tx_count, 1);
    check("norm_busy_run", 32'(busy), 32'd1);
    send_word(32'h0000_0002, 1'b1);
    step();
    send_word(32'hDEAD_BEEF, 1'b1);
    send_word(32'h0123_4567, 1'b0);
    check("norm_we_latency", 32'(imem_we), 32'd1);
    step();
    check("norm_done", 32'(done), 32'd1);
    check("norm_busy", 32'(busy), 32'd0);
    expect_write(0, 32'hDEAD_BEEF);
    expect_write(1, 32'h0123_4567);
    compare_writes("norm");

    // Busy transmitter; a byte sent before the request goes out is dropped.
    do_reset();
    tx_busy = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h55);
    for (int i = 0; i < 18; i++) step();
    check("txb_no_start", tx_count, 0);
    check("txb_busy", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    step();
    check("txb_one_start", tx_count, 1);
    check("txb_start_while_busy", tx_bad, 0);
    send_word(32'h0000_0001, 1'b1);
    step();
    send_word(32'h1122_3344, 1'b1);
    check("txb_done", 32'(done), 32'd1);
    expect_write(0, 32'h1122_3344);
    compare_writes("txb");

    // Back-to-back data bytes; byte 0 of word 2 coincides with the WRITE cycle.
    do_reset();
    do_start();
    send_word(32'h0000_0002, 1'b0);
    step();
    send_word(32'hA1B2_C3D4, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    step();
    check("b2b_done", 32'(done), 32'd1);
    expect_write(0, 32'hA1B2_C3D4);
    expect_write(1, 32'h5566_7788);
    compare_writes("b2b");

    // Zero length.
    do_reset();
    do_start();
    send_word(32'h0000_0000, 1'b0);
    check("len0_check_busy", 32'(busy), 32'd1);
    check("len0_check_done", 32'(done), 32'd0);
    step();
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    compare_writes("len0");

    // One past capacity (17 with ADDR_W=4).
    do_reset();
    do_start();
    send_word(32'h0000_0011, 1'b0);
    check("over_check_err", 32'(err), 32'd0);
    step();
    check("over_err", 32'(err), 32'd1);
    check("over_busy", 32'(busy), 32'd0);
    check("over_done", 32'(done), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("over_err_sticky", 32'(err), 32'd1);
    check("over_start_ignored", tx_count, 1);
    compare_writes("over");

    // Exactly capacity: 16 words.
    do_reset();
    do_start();
    send_word(32'h0000_0010, 1'b0);
    step();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      w = {8'(i), 8'(i) ^ 8'h5A, 8'hC0 + 8'(i), 8'(15 - i)};
      send_word(w, (i % 2) == 1);
      expect_write(AW'(i), w);
    end
    step();
    check("cap_done", 32'(done), 32'd1);
    check("cap_err", 32'(err), 32'd0);
    compare_writes("cap");

    // Reset in the middle of the first word, then a full reload.
    do_reset();
    do_start();
    send_word(32'h0000_0002, 1'b0);
    step();
    send_byte(8'hDE);
    send_byte(8'hAD);
    rstn = 1'b0;
    step();
    check_reset_outputs("mid");
    rstn = 1'b1;
    compare_writes("mid_partial");
    tx_count = 0;
    do_start();
    check("mid_tx_count", tx_count, 1);
    send_word(32'h0000_0002, 1'b0);
    step();
    send_word(32'hCAFE_F00D, 1'b1);
    send_word(32'h0BAD_F00D, 1'b0);
    step();
    check("mid_done", 32'(done), 32'd1);
    expect_write(0, 32'hCAFE_F00D);
    expect_write(1, 32'h0BAD_F00D);
    compare_writes("mid");

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
